// File: rtl/robot_pkg.sv
// Shared encodings for the tracked-robot drive controller: FSM states,
// remote-control move codes and per-track direction codes.
package robot_pkg;

  typedef enum logic [2:0] {
    PWR_OFF,
    ENGINE_START,
    IDLE,
    DRIVE,
    BRAKE,
    TRK_ERR,
    ENGINE_END
  } state_t;

  localparam logic [2:0] MV_FWD     = 3'b111;
  localparam logic [2:0] MV_BACK    = 3'b011;
  localparam logic [2:0] MV_LEFT_A  = 3'b101;
  localparam logic [2:0] MV_LEFT_B  = 3'b010;
  localparam logic [2:0] MV_RIGHT_A = 3'b110;
  localparam logic [2:0] MV_RIGHT_B = 3'b001;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_BACK = 2'b10;

  // Direction pairs are {left, right}; equal pairs mean "same direction".
  localparam logic [3:0] PAIR_STOP = {DIR_STOP, DIR_STOP};
  localparam logic [3:0] PAIR_FWD  = {DIR_FWD, DIR_FWD};
  localparam logic [3:0] PAIR_BACK = {DIR_BACK, DIR_BACK};

  function automatic logic [3:0] move_to_dirs(input logic [2:0] move);
    logic [3:0] pair;
    pair = PAIR_STOP;
    case (move)
      MV_FWD:                 pair = PAIR_FWD;
      MV_BACK:                pair = PAIR_BACK;
      MV_LEFT_A, MV_LEFT_B:   pair = {DIR_BACK, DIR_FWD};
      MV_RIGHT_A, MV_RIGHT_B: pair = {DIR_FWD, DIR_BACK};
      default:                pair = PAIR_STOP;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/robot_pwm.sv
// Two-channel PWM generator sharing one free-running counter; period is
// 2^SPEED_W-1 cycles so an all-ones speed yields a constant high output.
module robot_pwm #(
  parameter int SPEED_W = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [SPEED_W-1:0] cur_speed,
  input  logic [1:0]         left_dir,
  input  logic [1:0]         right_dir,
  output logic               left_pwm,
  output logic               right_pwm
);

  localparam logic [SPEED_W-1:0] CNT_MAX = SPEED_W'((1 << SPEED_W) - 2);

  logic [SPEED_W-1:0] cnt_q;
  logic               duty_on;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign duty_on   = (cnt_q < cur_speed);
  assign left_pwm  = duty_on && (left_dir != 2'b00);
  assign right_pwm = duty_on && (right_dir != 2'b00);

endmodule

// File: rtl/robot_drive_ctrl.sv
// Tracked-robot drive controller: engine warm-up, ramped per-command speed,
// brake-before-reverse, front/rear obstacle stop and PWM track outputs.
module robot_drive_ctrl
  import robot_pkg::*;
#(
  parameter int SPEED_W    = 4,
  parameter int WARMUP_CYC = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               motor_on_i,
  input  logic [2:0]         move_i,
  input  logic [SPEED_W-1:0] speed_i,
  input  logic               tracker_fwrd_i,
  input  logic               tracker_back_i,
  output logic               motor_status_o,
  output logic [1:0]         left_motor_o,
  output logic [1:0]         right_motor_o,
  output logic               left_pwm_o,
  output logic               right_pwm_o,
  output logic [SPEED_W-1:0] cur_speed_o,
  output logic               tracker_status_o
);

  localparam int WCNT_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP_CYC - 1);

  state_t             state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d, ramp_speed;
  logic [3:0]         dir_q, dir_d, pend_q, pend_d, move_dirs;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               dir_blocked, cmd_blocked, drive_active;

  assign move_dirs   = move_to_dirs(move_i);
  assign dir_blocked = ((dir_q == PAIR_FWD) && tracker_fwrd_i) ||
                       ((dir_q == PAIR_BACK) && tracker_back_i);
  assign cmd_blocked = ((move_dirs == PAIR_FWD) && tracker_fwrd_i) ||
                       ((move_dirs == PAIR_BACK) && tracker_back_i);

  always_comb begin
    ramp_speed = speed_q;
    if (speed_q < speed_i)      ramp_speed = speed_q + 1'b1;
    else if (speed_q > speed_i) ramp_speed = speed_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= PWR_OFF;
      speed_q <= '0;
      dir_q   <= PAIR_STOP;
      pend_q  <= PAIR_STOP;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      PWR_OFF: begin
        if (motor_on_i) begin
          state_d = ENGINE_START;
          wcnt_d  = '0;
        end
      end
      ENGINE_START: begin
        if (!motor_on_i)              state_d = PWR_OFF;
        else if (wcnt_q == WCNT_LAST) state_d = IDLE;
        else                          wcnt_d  = wcnt_q + 1'b1;
      end
      IDLE: begin
        if (!motor_on_i) begin
          state_d = ENGINE_END;
        end else if ((move_dirs != PAIR_STOP) && !cmd_blocked) begin
          dir_d   = move_dirs;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (dir_blocked) begin
          speed_d = '0;
          state_d = TRK_ERR;
        end else if (!motor_on_i) begin
          state_d = ENGINE_END;
        end else if (move_dirs == dir_q) begin
          speed_d = ramp_speed;
        end else begin
          pend_d  = move_dirs;
          state_d = BRAKE;
        end
      end
      BRAKE: begin
        if (dir_blocked) begin
          speed_d = '0;
          state_d = TRK_ERR;
        end else if (!motor_on_i) begin
          state_d = ENGINE_END;
        end else if (speed_q == '0) begin
          // Reached standstill: only now may the track direction change.
          if (pend_q != PAIR_STOP) begin
            dir_d   = pend_q;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          speed_d = speed_q - 1'b1;
          pend_d  = move_dirs;
        end
      end
      TRK_ERR: begin
        if (!motor_on_i) begin
          state_d = ENGINE_END;
        end else if (!tracker_fwrd_i && !tracker_back_i && (move_dirs == PAIR_STOP)) begin
          state_d = IDLE;
        end
      end
      ENGINE_END: begin
        if (speed_q == '0)    state_d = PWR_OFF;
        else if (dir_blocked) speed_d = '0;
        else                  speed_d = speed_q - 1'b1;
      end
      default: state_d = PWR_OFF;
    endcase
  end

  assign drive_active     = ((state_q == DRIVE) || (state_q == BRAKE) ||
                             (state_q == ENGINE_END)) && (speed_q != '0);
  assign left_motor_o     = drive_active ? dir_q[3:2] : DIR_STOP;
  assign right_motor_o    = drive_active ? dir_q[1:0] : DIR_STOP;
  assign motor_status_o   = (state_q != PWR_OFF) && (state_q != ENGINE_START);
  assign tracker_status_o = (state_q == TRK_ERR);
  assign cur_speed_o      = speed_q;

  robot_pwm #(
    .SPEED_W (SPEED_W)
  ) u_pwm (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .cur_speed (speed_q),
    .left_dir  (left_motor_o),
    .right_dir (right_motor_o),
    .left_pwm  (left_pwm_o),
    .right_pwm (right_pwm_o)
  );

endmodule

// File: doc/robot_drive_ctrl.md
Name: robot_drive_ctrl

Overview:
Parametrised successor of the tracked-robot motor controller. Keeps the same remote-control move codes and obstacle handling. Adds a timed engine warm-up, per-command speed with linear ramp up and down, braking before any direction reversal, a rear obstacle sensor, and PWM drive outputs for both tracks. It sits between the remote-control receiver and the two track motor drivers.

Parameters:
SPEED_W, 4, width of the speed command and PWM resolution; all-ones means 100% duty.
WARMUP_CYC, 8, number of cycles spent in ENGINE_START; must be at least 1.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  reset, asynchronous, active-low.
motor_on_i  in  1  engine enable.
move_i  in  3  command: 111 fwd, 101/010 left, 110/001 right, 011 back; all other codes (000, 100) mean stop.
speed_i  in  SPEED_W  target speed.
tracker_fwrd_i  in  1  front obstacle present.
tracker_back_i  in  1  rear obstacle present.
motor_status_o  out  1  engine running (IDLE, DRIVE, BRAKE, TRK_ERR, ENGINE_END).
left_motor_o  out  2  left track direction: 00 stop, 01 fwd, 10 back.
right_motor_o  out  2  right track direction, same encoding.
left_pwm_o  out  1  left track PWM.
right_pwm_o  out  1  right track PWM.
cur_speed_o  out  SPEED_W  current ramped speed.
tracker_status_o  out  1  high while in TRK_ERR.

Behaviour:
- Reset values: state PWR_OFF, cur_speed 0, dir register stop, warm-up counter 0, PWM counter 0.
- Outputs at reset: all outputs 0.
- Outputs are Moore: decoded from registers only, so no combinational path from any input to any output.
- Direction outputs: equal the dir register when state is DRIVE, BRAKE or ENGINE_END and cur_speed is nonzero; 00 otherwise.
- Direction mapping:
  - fwd: L=01, R=01.
  - back: L=10, R=10.
  - left: L=10, R=01.
  - right: L=01, R=10.
- PWR_OFF:
  - motor_on_i=1 -> ENGINE_START, warm-up counter cleared.
- ENGINE_START:
  - Counts for exactly WARMUP_CYC cycles, then -> IDLE.
  - motor_on_i=0 during warm-up -> PWR_OFF immediately.
- IDLE:
  - motor_on_i=0 -> ENGINE_END.
  - Otherwise a valid move code latches dir -> DRIVE, with cur_speed at 0.
  - A forward command while tracker_fwrd_i=1, or a back command while tracker_back_i=1, is refused: stay in IDLE.
- DRIVE ramp:
  - Each cycle, cur_speed moves one step toward speed_i (+1, -1 or hold).
  - speed_i may change at any time; the ramp tracks it.
- DRIVE command changes:
  - Same direction code (including the alternate encoding for the same direction) -> keep ramping.
  - Different direction, or a stop code -> BRAKE, with the pending code latched.
- BRAKE:
  - cur_speed decrements by 1 per cycle.
  - At 0: a pending direction is loaded into dir -> DRIVE; a pending stop -> IDLE.
  - A new command arriving during BRAKE overwrites the pending code.
- Obstacles:
  - In DRIVE or BRAKE with dir=fwd and tracker_fwrd_i=1, or dir=back and tracker_back_i=1: cur_speed is forced to 0 on the next edge (no ramp) and the state goes to TRK_ERR.
  - Turns ignore both trackers.
- TRK_ERR:
  - tracker_status_o=1 and both tracks are stopped.
  - Leaves to IDLE on the first cycle both trackers are 0 and move_i is a stop code, so the operator must release the stick.
  - motor_on_i=0 -> ENGINE_END.
- motor_on_i=0 in DRIVE or BRAKE -> ENGINE_END.
- ENGINE_END:
  - Ramps cur_speed down by 1 per cycle with dir held.
  - At cur_speed 0 -> PWR_OFF.
  - Obstacle forcing still applies in this state.
- PWM:
  - Free-running counter over 0 .. 2^SPEED_W-2, so the period is 2^SPEED_W-1 cycles.
  - Each pwm output is high when the counter is below cur_speed and the track's direction output is non-zero.
  - Speed 0 gives a constant low output; all-ones gives a constant high output.
- Widths: the ramp saturates and never wraps; the comparison is unsigned.
- Reset asserted mid-operation returns every register to its reset value asynchronously.

Decomposition:
- Package robot_pkg holds:
  - the state encoding localparams (PWR_OFF, ENGINE_START, IDLE, DRIVE, BRAKE, TRK_ERR, ENGINE_END);
  - the move code constants;
  - the direction codes (STOP, FWD, BACK);
  - a function mapping a move code to a {left, right} direction pair.
- One sub-module, robot_pwm (parameter SPEED_W): holds the PWM counter and drives both channel comparators from cur_speed and the two direction outputs.

Test Plan:
- All tests use SPEED_W=4, WARMUP_CYC=8.
- Power-up: reset, then motor_on_i=1 -> motor_status_o rises exactly 9 edges after motor_on_i is first sampled; all other outputs stay 0 until then.
- Forward ramp: move_i=111, speed_i=15 -> L/R=01 from the first nonzero speed; cur_speed reaches 15 after 16 edges; left_pwm_o and right_pwm_o then stay constantly high. With speed_i=5, PWM is high 5 of every 15 cycles.
- Reversal: at speed 10 fwd, move_i=011 -> 10 decrementing cycles with L/R=01, then L/R=10 ramping up from 0; no cycle ever shows fwd and back on the same track.
- Obstacle: at speed 12 fwd, tracker_fwrd_i=1 -> next edge gives cur_speed=0, tracker_status_o=1 and L/R=00. Clearing the tracker with move_i still 111 keeps TRK_ERR; move_i=000 -> IDLE. A fwd command in IDLE with the tracker high is refused.
- Turn with obstacle: move_i=101, tracker_fwrd_i=1 -> L=10, R=01, ramping normally with no error.
- Shutdown: motor_on_i=0 at speed 6 -> 6-cycle ramp down, then PWR_OFF with motor_status_o=0. Reset asserted mid-DRIVE -> all outputs 0 immediately.
